nxd_timer: RTL and testbench



---
 rtl/nxd_pkg.sv | 17 +
 rtl/nxd_counter.sv | 43 ++++
 rtl/nxd_timer.sv | 134 +++++++++++++
 tb/tb_nxd_timer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/nxd_pkg.sv
// nxd_pkg: shared definitions for the nxd_timer bus-cycle watchdog.
//   - default parameter values (counter width, timeout, address width)
//   - FSM state encoding kept as plain localparam constants so that legacy
//     code comparing raw state values keeps working.
package nxd_pkg;

    localparam int unsigned NXD_CNT_WIDTH  = 8;
    localparam int unsigned NXD_TIMEOUT    = 127;
    localparam int unsigned NXD_ADDR_WIDTH = 20;

    typedef logic [1:0] nxd_state_t;

    localparam nxd_state_t NXD_IDLE  = 2'd0;
    localparam nxd_state_t NXD_ABORT = 2'd1;
    localparam nxd_state_t NXD_WAIT  = 2'd2;

endpackage

// File: rtl/nxd_counter.sv
// nxd_counter: saturating up-counter with synchronous clear and terminal count.
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous reset, active-low
//   i_en     clock enable; nothing changes while low
//   i_clr    clear to zero (wins over increment)
//   i_inc    increment request; ignored once the terminal count is reached
//   o_tc     high while the count equals TERM-1
module nxd_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TERM  = 127
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERM - 1);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             w_tc;

    assign w_tc = (r_count == TC_VAL);
    assign o_tc = w_tc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_count <= '0;
            end else if (i_inc && !w_tc) begin
                // Saturate at the terminal value; the counter never wraps.
                r_count <= r_count + ONE;
            end
        end
    end

endmodule

// File: rtl/nxd_timer.sv
// nxd_timer: bus-cycle watchdog for the KS-10 CPU.
// Times each outstanding memory/IO bus cycle. If no acknowledge arrives
// within TIMEOUT enabled clocks, the cycle is aborted with a one-cycle pulse
// and a sticky error is raised: nxdErr for IO cycles, nxmErr for memory.
// Optional feature: define NXD_CAPTURE_EN to capture the address of the
// cycle that raised the first error on errADDR; otherwise errADDR is 0.
// Ports:
//   clk      CPU clock
//   rst      synchronous reset, active-low
//   clken    clock enable; all state advances only when high
//   iolatch  IO cycle flag, sampled at cycle start
//   busREQ   bus cycle request
//   busACK   device/memory acknowledge
//   busADDR  cycle address, sampled at cycle start (capture build only)
//   errClr   clears sticky errors
//   busy     a cycle is being timed
//   abort    one-enabled-cycle pulse terminating the hung cycle
//   nxdErr   sticky non-existent IO device
//   nxmErr   sticky non-existent memory
//   errADDR  address of the failing cycle (capture build only)
module nxd_timer
    import nxd_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = NXD_CNT_WIDTH,
    parameter int unsigned TIMEOUT    = NXD_TIMEOUT,
    parameter int unsigned ADDR_WIDTH = NXD_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clken,
    input  logic                  iolatch,
    input  logic                  busREQ,
    input  logic                  busACK,
    input  logic [ADDR_WIDTH-1:0] busADDR,
    input  logic                  errClr,
    output logic                  busy,
    output logic                  abort,
    output logic                  nxdErr,
    output logic                  nxmErr,
    output logic [ADDR_WIDTH-1:0] errADDR
);

    nxd_state_t r_state;
    nxd_state_t w_state_nxt;
    logic       r_isio;
    logic       r_abort;
    logic       r_nxd;
    logic       r_nxm;
    logic       w_tc;
    logic       w_start;
    logic       w_fire;
    logic       w_set;

    assign w_start = (r_state == NXD_IDLE) && busREQ;
    assign w_fire  = (r_state == NXD_WAIT) && !busACK && w_tc;
    // The error is set on entry to ABORT (so it rises with abort) and held
    // set during ABORT, so an errClr landing on the abort cycle cannot win.
    assign w_set   = w_fire || (r_state == NXD_ABORT);

    nxd_counter #(
        .WIDTH (CNT_WIDTH),
        .TERM  (TIMEOUT)
    ) u_counter (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_en    (clken),
        .i_clr   (r_state != NXD_WAIT),
        .i_inc   (!busACK),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            NXD_IDLE: begin
                if (busREQ) w_state_nxt = NXD_WAIT;
            end
            NXD_WAIT: begin
                if (busACK)    w_state_nxt = NXD_IDLE;
                else if (w_tc) w_state_nxt = NXD_ABORT;
            end
            NXD_ABORT: w_state_nxt = NXD_IDLE;
            default:   w_state_nxt = NXD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= NXD_IDLE;
            r_isio  <= 1'b0;
            r_abort <= 1'b0;
            r_nxd   <= 1'b0;
            r_nxm   <= 1'b0;
        end else if (clken) begin
            r_state <= w_state_nxt;
            if (w_start) r_isio <= iolatch;
            r_abort <= w_fire;
            r_nxd   <= (w_set && r_isio)  || (r_nxd && !errClr);
            r_nxm   <= (w_set && !r_isio) || (r_nxm && !errClr);
        end
    end

    assign busy   = (r_state != NXD_IDLE);
    assign abort  = r_abort;
    assign nxdErr = r_nxd;
    assign nxmErr = r_nxm;

`ifdef NXD_CAPTURE_EN
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_err_addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr     <= '0;
            r_err_addr <= '0;
        end else if (clken) begin
            if (w_start) r_addr <= busADDR;
            // Only the first error since the last clear records its address.
            if (w_fire && !r_nxd && !r_nxm) begin
                r_err_addr <= r_addr;
            end else if (errClr) begin
                r_err_addr <= '0;
            end
        end
    end

    assign errADDR = r_err_addr;
`else
    logic w_unused_addr;
    assign w_unused_addr = ^busADDR;
    assign errADDR       = '0;
`endif

endmodule

// File: tb/tb_nxd_timer.sv
// tb_nxd_timer: self-checking bench for nxd_timer.
// Directed scenarios followed by randomized traffic; every output is compared
// each clock against a transaction-level reference model.
module tb_nxd_timer;

    localparam int unsigned TO = 4;
    localparam int unsigned AW = 20;
`ifdef NXD_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, clken, iolatch, busREQ, busACK, errClr;
    logic [AW-1:0] busADDR;
    logic          busy, abort, nxdErr, nxmErr;
    logic [AW-1:0] errADDR;

    always #5 clk = ~clk;

    nxd_timer #(
        .CNT_WIDTH  (8),
        .TIMEOUT    (TO),
        .ADDR_WIDTH (AW)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .clken   (clken),
        .iolatch (iolatch),
        .busREQ  (busREQ),
        .busACK  (busACK),
        .busADDR (busADDR),
        .errClr  (errClr),
        .busy    (busy),
        .abort   (abort),
        .nxdErr  (nxdErr),
        .nxmErr  (nxmErr),
        .errADDR (errADDR)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: one outstanding transaction, measured by the number
    // of enabled clocks it has waited without acknowledge.
    bit          m_busy = 0, m_abort = 0, m_isio = 0, m_nxd = 0, m_nxm = 0;
    int unsigned m_wait = 0;
    logic [AW-1:0] m_addr = '0, m_eaddr = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        bit in_abort, fire, set_any;
        if (!rst) begin
            m_busy = 0; m_abort = 0; m_isio = 0; m_nxd = 0; m_nxm = 0;
            m_wait = 0; m_addr = '0; m_eaddr = '0;
        end else if (clken) begin
            in_abort = m_abort;
            fire     = 0;
            if (m_abort) begin
                m_abort = 0;
                m_busy  = 0;
            end else if (m_busy) begin
                if (busACK) m_busy = 0;
                else begin
                    m_wait++;
                    if (m_wait == TO) begin
                        fire    = 1;
                        m_abort = 1;
                    end
                end
            end else if (busREQ) begin
                m_busy = 1; m_wait = 0; m_isio = iolatch; m_addr = busADDR;
            end
            set_any = fire | in_abort;
            if (fire && !m_nxd && !m_nxm) m_eaddr = m_addr;
            else if (errClr)              m_eaddr = '0;
            m_nxd = (set_any && m_isio)  || (m_nxd && !errClr);
            m_nxm = (set_any && !m_isio) || (m_nxm && !errClr);
        end
    endtask

    task automatic step(input logic r, input logic ce, input logic io, input logic req,
                        input logic ack, input logic clr, input logic [AW-1:0] a);
        rst = r; clken = ce; iolatch = io; busREQ = req; busACK = ack; errClr = clr; busADDR = a;
        @(posedge clk);
        model_update();
        #1;
        chk("busy",   {31'd0, busy},   {31'd0, m_busy});
        chk("abort",  {31'd0, abort},  {31'd0, m_abort});
        chk("nxdErr", {31'd0, nxdErr}, {31'd0, m_nxd});
        chk("nxmErr", {31'd0, nxmErr}, {31'd0, m_nxm});
        chk("errADDR", 32'(errADDR), CAP ? 32'(m_eaddr) : 32'd0);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, '0);
    endtask

    // Issue an IO request, then count raw clocks until abort is seen.
    task automatic measure(input bit toggle, output int unsigned raw);
        step(1, 1, 1, 1, 0, 0, 20'h00001);
        raw = 0;
        for (int unsigned i = 1; i <= 40; i++) begin
            step(1, toggle ? (i % 2 == 0) : 1'b1, 0, 0, 0, 0, '0);
            if (abort) begin
                raw = i;
                break;
            end
        end
        step(1, 1, 0, 0, 0, 0, '0);
        step(1, 1, 0, 0, 0, 1, '0);
    endtask

    initial begin
        int unsigned lat;
        logic [AW-1:0] a;

        // Reset with request and ack held high.
        for (int unsigned i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 0, 20'hFFFFF);
        chk("rst_busy",  {31'd0, busy},   32'd0);
        chk("rst_abort", {31'd0, abort},  32'd0);
        chk("rst_nxd",   {31'd0, nxdErr}, 32'd0);
        chk("rst_nxm",   {31'd0, nxmErr}, 32'd0);
        chk("rst_addr",  32'(errADDR),    32'd0);
        idle(1);
        chk("rst_idle", {31'd0, busy}, 32'd0);

        // Normal acknowledged IO cycle.
        step(1, 1, 1, 1, 0, 0, 20'h00AAA);
        chk("ack_busy_rise", {31'd0, busy}, 32'd1);
        idle(2);
        step(1, 1, 0, 0, 1, 0, '0);
        chk("ack_busy_fall", {31'd0, busy},   32'd0);
        chk("ack_no_nxd",    {31'd0, nxdErr}, 32'd0);

        // IO timeout, latency in enabled clocks.
        measure(0, lat);
        chk("lat_enabled", lat, TO);
        chk("io_cleared", {31'd0, nxdErr}, 32'd0);

        // clken toggling doubles the latency in raw clocks.
        measure(1, lat);
        chk("lat_toggled", lat, 2 * TO);

        // Memory timeout with capture, then a second timeout.
        step(1, 1, 0, 1, 0, 0, 20'h30104);
        idle(TO + 1);
        chk("mem_nxm", {31'd0, nxmErr}, 32'd1);
        chk("mem_nxd", {31'd0, nxdErr}, 32'd0);
        chk("cap_addr1", 32'(errADDR), CAP ? 32'h30104 : 32'd0);
        step(1, 1, 0, 1, 0, 0, 20'h00010);
        idle(TO + 1);
        chk("cap_addr2", 32'(errADDR), CAP ? 32'h30104 : 32'd0);

        // errClr together with a new request: both take effect.
        step(1, 1, 1, 1, 0, 1, 20'h00055);
        chk("clr_req_busy", {31'd0, busy},   32'd1);
        chk("clr_req_nxm",  {31'd0, nxmErr}, 32'd0);
        step(1, 1, 0, 0, 1, 0, '0);

        // ACK on the exact terminal cycle wins.
        step(1, 1, 1, 1, 0, 0, 20'h00077);
        idle(TO - 1);
        step(1, 1, 0, 0, 1, 0, '0);
        chk("term_ack_abort", {31'd0, abort},  32'd0);
        chk("term_ack_nxd",   {31'd0, nxdErr}, 32'd0);
        idle(2);

        // errClr and busACK during the abort cycle: the abort and set win.
        step(1, 1, 1, 1, 0, 0, 20'h00099);
        idle(TO);
        chk("abort_seen", {31'd0, abort}, 32'd1);
        step(1, 1, 0, 0, 1, 1, '0);
        chk("setwins_nxd", {31'd0, nxdErr}, 32'd1);
        chk("abort_done",  {31'd0, busy},   32'd0);
        step(1, 1, 0, 0, 0, 1, '0);

        // Reset mid-cycle sets no error.
        step(1, 1, 0, 1, 0, 0, 20'h00123);
        idle(TO - 1);
        step(0, 1, 0, 0, 0, 0, '0);
        idle(TO + 2);
        chk("midrst_nxm", {31'd0, nxmErr}, 32'd0);

        // Randomized traffic.
        for (int unsigned i = 0; i < 4000; i++) begin
            a = AW'($urandom);
            step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0, a);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
